// File: rtl/grf_hazard_ctrl_if.sv
// D-stage request / hazard response bundle between the decode stage and grf_hazard_ctrl.
interface grf_hazard_ctrl_if #(
    parameter int TNEW_W = 2
);
    logic              d_valid;
    logic [4:0]        d_rs;
    logic [4:0]        d_rt;
    logic              d_rs_use;
    logic              d_rt_use;
    logic [TNEW_W-1:0] d_rs_tuse;
    logic [TNEW_W-1:0] d_rt_tuse;
    logic              d_wr;
    logic [4:0]        d_dst;
    logic [TNEW_W-1:0] d_tnew;
    logic              flush;
    logic              stall;
    logic [1:0]        fwd_rs;
    logic [1:0]        fwd_rt;

    modport master (
        output d_valid, d_rs, d_rt, d_rs_use, d_rt_use, d_rs_tuse, d_rt_tuse,
               d_wr, d_dst, d_tnew, flush,
        input  stall, fwd_rs, fwd_rt
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_rs_use, d_rt_use, d_rs_tuse, d_rt_tuse,
               d_wr, d_dst, d_tnew, flush,
        output stall, fwd_rs, fwd_rt
    );
endinterface

// File: rtl/grf_hazard_ctrl.sv
// GRF scoreboard hazard controller: E/M/W writer slots, per-read-port stall/forward select.
// Define GRF_HAZ_STATS_EN to add the 32-bit stall_cnt statistics port.

// One GRF read port: youngest matching writer decides stall or forward source.
module grf_haz_port #(
    parameter int TNEW_W = 2,
    parameter int STAGES = 3
) (
    input  logic [4:0]                    src,
    input  logic                          rd,
    input  logic [TNEW_W-1:0]             tuse,
    input  logic [STAGES-1:0]             vld,
    input  logic [STAGES-1:0][4:0]        dst,
    input  logic [STAGES-1:0][TNEW_W-1:0] tnew,
    output logic [1:0]                    fwd,
    output logic                          req
);
    logic hit;

    always_comb begin
        fwd = 2'd0;
        req = 1'b0;
        hit = 1'b0;
        if (rd && src != 5'd0) begin
            // index 0 is E, so the first hit is the youngest writer
            for (int i = 0; i < STAGES; i++) begin
                if (!hit && vld[i] && dst[i] == src) begin
                    hit = 1'b1;
                    if (tnew[i] > tuse) req = 1'b1;
                    else                fwd = 2'(i + 1);
                end
            end
        end
    end
endmodule

module grf_hazard_ctrl #(
    parameter int TNEW_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    grf_hazard_ctrl_if.slave      bus
`ifdef GRF_HAZ_STATS_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);
    localparam int NUM_PORTS = 2;
    localparam int STAGES    = 3;

    logic [STAGES-1:0]             vld_pipe;
    logic [STAGES-1:0][4:0]        dst_pipe;
    logic [STAGES-1:0][TNEW_W-1:0] tnew_pipe;

    logic [NUM_PORTS-1:0][4:0]        src;
    logic [NUM_PORTS-1:0]             rd;
    logic [NUM_PORTS-1:0][TNEW_W-1:0] tuse;
    logic [NUM_PORTS-1:0][1:0]        fwd;
    logic [NUM_PORTS-1:0]             req;
    logic                             stall;

    function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    assign src  = {bus.d_rt, bus.d_rs};
    assign rd   = {bus.d_rt_use, bus.d_rs_use};
    assign tuse = {bus.d_rt_tuse, bus.d_rs_tuse};

    grf_haz_port #(.TNEW_W(TNEW_W), .STAGES(STAGES)) u_port [NUM_PORTS-1:0] (
        .src  (src),
        .rd   (rd),
        .tuse (tuse),
        .vld  (vld_pipe),
        .dst  (dst_pipe),
        .tnew (tnew_pipe),
        .fwd  (fwd),
        .req  (req)
    );

    assign stall      = bus.d_valid & (|req) & ~bus.flush;
    assign bus.stall  = stall;
    assign bus.fwd_rs = fwd[0];
    assign bus.fwd_rt = fwd[1];

    // Every stage ages its tnew on the move, so a W-resident result is always ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe  <= '0;
            dst_pipe  <= '0;
            tnew_pipe <= '0;
        end else begin
            vld_pipe[0]  <= bus.d_valid & bus.d_wr & ~stall & ~bus.flush & (bus.d_dst != 5'd0);
            dst_pipe[0]  <= bus.d_dst;
            tnew_pipe[0] <= bus.d_tnew;
            for (int i = 1; i < STAGES; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                dst_pipe[i]  <= dst_pipe[i-1];
                tnew_pipe[i] <= dec_sat(tnew_pipe[i-1]);
            end
        end
    end

`ifdef GRF_HAZ_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     stall_cnt <= 32'd0;
        else if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Self-checking bench for grf_hazard_ctrl: directed hazard scenarios plus random traffic vs an age-based model.
module tb_grf_hazard_ctrl;
    localparam int TNEW_W = 2;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    grf_hazard_ctrl_if #(.TNEW_W(TNEW_W)) bus ();

`ifdef GRF_HAZ_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] exp_cnt;
    grf_hazard_ctrl #(.TNEW_W(TNEW_W)) dut (.clk(clk), .reset(reset), .bus(bus), .stall_cnt(stall_cnt));
`else
    grf_hazard_ctrl #(.TNEW_W(TNEW_W)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: hist[k] is whatever entered E k cycles ago; its result is ready once k >= tnew.
    typedef struct { bit vld; bit [4:0] dst; int tnew; } ent_t;
    ent_t hist[$];
    bit   exp_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void mport(input logic [4:0] src, input logic rd, input int tuse,
                                  output int fwd, output bit req);
        int rem;
        fwd = 0;
        req = 0;
        if (rd && src != 5'd0) begin
            for (int k = 0; k < hist.size(); k++) begin
                if (hist[k].vld && hist[k].dst == src) begin
                    rem = hist[k].tnew - k;
                    if (rem < 0) rem = 0;
                    if (rem > tuse) req = 1;
                    else            fwd = k + 1;
                    break;
                end
            end
        end
    endfunction

    task automatic idle();
        bus.d_valid = 0; bus.d_rs = 0; bus.d_rt = 0; bus.d_rs_use = 0; bus.d_rt_use = 0;
        bus.d_rs_tuse = 0; bus.d_rt_tuse = 0; bus.d_wr = 0; bus.d_dst = 0; bus.d_tnew = 0;
        bus.flush = 0;
    endtask

    task automatic wr_op(input int dst, input int tnew);
        idle();
        bus.d_valid = 1; bus.d_wr = 1; bus.d_dst = 5'(dst); bus.d_tnew = TNEW_W'(tnew);
    endtask

    task automatic rd_rs(input int r, input int t);
        idle();
        bus.d_valid = 1; bus.d_rs = 5'(r); bus.d_rs_use = 1; bus.d_rs_tuse = TNEW_W'(t);
    endtask

    task automatic rd_rt(input int r, input int t);
        idle();
        bus.d_valid = 1; bus.d_rt = 5'(r); bus.d_rt_use = 1; bus.d_rt_tuse = TNEW_W'(t);
    endtask

    // Called at the falling edge after inputs are set; compares combinational outputs.
    task automatic check_cycle();
        int  frs, frt;
        bit  qrs, qrt;
        #1;
        if (!reset) begin
            hist.delete();
`ifdef GRF_HAZ_STATS_EN
            exp_cnt = 0;
`endif
        end
        mport(bus.d_rs, bus.d_rs_use, int'(bus.d_rs_tuse), frs, qrs);
        mport(bus.d_rt, bus.d_rt_use, int'(bus.d_rt_tuse), frt, qrt);
        exp_stall = bus.d_valid && (qrs || qrt) && !bus.flush;
        chk("stall", 32'(bus.stall), 32'(exp_stall));
        chk("fwd_rs", 32'(bus.fwd_rs), 32'(frs));
        chk("fwd_rt", 32'(bus.fwd_rt), 32'(frt));
`ifdef GRF_HAZ_STATS_EN
        chk("stall_cnt", stall_cnt, exp_cnt);
`endif
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (reset) begin
            e.vld  = bus.d_valid && bus.d_wr && !exp_stall && !bus.flush && bus.d_dst != 5'd0;
            e.dst  = bus.d_dst;
            e.tnew = int'(bus.d_tnew);
            hist.push_front(e);
            if (hist.size() > 3) void'(hist.pop_back());
`ifdef GRF_HAZ_STATS_EN
            if (exp_stall) exp_cnt = exp_cnt + 32'd1;
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_stall = 0;
`ifdef GRF_HAZ_STATS_EN
        exp_cnt = 0;
`endif
        idle();
        reset = 0;
        @(negedge clk);
        check_cycle(); tick();
        reset = 1;

        // Reset while E holds a $8 writer: outputs clear at once, then empty slots
        wr_op(8, 2); check_cycle(); tick();
        rd_rs(8, 0); check_cycle();
        chk("pre_reset_stall", 32'(bus.stall), 32'd1);
        reset = 0; check_cycle();
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_fwd_rs", 32'(bus.fwd_rs), 32'd0);
        tick();
        reset = 1;
        rd_rs(8, 0); check_cycle();
        chk("post_rst_stall", 32'(bus.stall), 32'd0);
        chk("post_rst_fwd_rs", 32'(bus.fwd_rs), 32'd0);
        tick();

        // Load-use, tuse 0: two stalls then W forward
        wr_op(8, 2); check_cycle(); tick();
        rd_rs(8, 0); check_cycle(); chk("lu0_s1", 32'(bus.stall), 32'd1); tick();
        check_cycle(); chk("lu0_s2", 32'(bus.stall), 32'd1); tick();
        check_cycle(); chk("lu0_go", 32'(bus.stall), 32'd0); chk("lu0_fwd", 32'(bus.fwd_rs), 32'd3); tick();
        idle(); for (int i = 0; i < 3; i++) begin check_cycle(); tick(); end

        // Load-use, tuse 1: one stall then M forward
        wr_op(8, 2); check_cycle(); tick();
        rd_rs(8, 1); check_cycle(); chk("lu1_s1", 32'(bus.stall), 32'd1); tick();
        check_cycle(); chk("lu1_go", 32'(bus.stall), 32'd0); chk("lu1_fwd", 32'(bus.fwd_rs), 32'd2); tick();
        idle(); for (int i = 0; i < 3; i++) begin check_cycle(); tick(); end

        // ALU chain
        wr_op(9, 1); check_cycle(); tick();
        rd_rt(9, 1); check_cycle(); chk("alu1_stall", 32'(bus.stall), 32'd0); chk("alu1_fwd", 32'(bus.fwd_rt), 32'd1); tick();
        idle(); for (int i = 0; i < 3; i++) begin check_cycle(); tick(); end
        wr_op(9, 1); check_cycle(); tick();
        rd_rt(9, 0); check_cycle(); chk("alu0_s1", 32'(bus.stall), 32'd1); tick();
        check_cycle(); chk("alu0_go", 32'(bus.stall), 32'd0); chk("alu0_fwd", 32'(bus.fwd_rt), 32'd2); tick();

        // Youngest writer wins
        wr_op(10, 0); check_cycle(); tick();
        wr_op(10, 0); check_cycle(); tick();
        rd_rs(10, 2); check_cycle(); chk("prio_stall", 32'(bus.stall), 32'd0); chk("prio_fwd", 32'(bus.fwd_rs), 32'd1); tick();

        // $0 never hazards
        wr_op(0, 2); check_cycle(); tick();
        rd_rs(0, 0); check_cycle(); chk("r0_stall", 32'(bus.stall), 32'd0); chk("r0_fwd", 32'(bus.fwd_rs), 32'd0); tick();

        // Flush beats stall and sends a bubble into E
        idle(); for (int i = 0; i < 3; i++) begin check_cycle(); tick(); end
        wr_op(8, 2); check_cycle(); tick();
        rd_rs(8, 0); bus.d_wr = 1; bus.d_dst = 11; bus.d_tnew = 1; bus.flush = 1;
        check_cycle(); chk("flush_stall", 32'(bus.stall), 32'd0); tick();
        rd_rt(11, 0); check_cycle(); chk("flush_bub_stall", 32'(bus.stall), 32'd0); chk("flush_bub_fwd", 32'(bus.fwd_rt), 32'd0); tick();

`ifdef GRF_HAZ_STATS_EN
        reset = 0; idle(); check_cycle(); tick(); reset = 1;
        for (int n = 0; n < 2; n++) begin
            wr_op(8, 2); check_cycle(); tick();
            rd_rs(8, 0); check_cycle(); tick(); check_cycle(); tick(); check_cycle(); tick();
        end
        wr_op(9, 1); check_cycle(); tick();
        rd_rt(9, 0); check_cycle(); tick();
        idle(); check_cycle();
        chk("cnt5", stall_cnt, 32'd5);
        tick();
        wr_op(12, 1); check_cycle(); tick();
        force dut.stall_cnt = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        rd_rs(12, 0); check_cycle();
        release dut.stall_cnt;
        tick();
        idle(); check_cycle();
        chk("cnt_wrap", stall_cnt, 32'd0);
        tick();
`endif

        // Random traffic on a small register set so hazards are frequent
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            bus.d_valid   = ($urandom_range(0, 7) != 0);
            bus.d_rs      = 5'($urandom_range(0, 3));
            bus.d_rt      = 5'($urandom_range(0, 3));
            bus.d_rs_use  = $urandom_range(0, 1) != 0;
            bus.d_rt_use  = $urandom_range(0, 1) != 0;
            bus.d_rs_tuse = TNEW_W'($urandom_range(0, 2));
            bus.d_rt_tuse = TNEW_W'($urandom_range(0, 2));
            bus.d_wr      = $urandom_range(0, 1) != 0;
            bus.d_dst     = 5'($urandom_range(0, 3));
            bus.d_tnew    = TNEW_W'($urandom_range(0, 2));
            bus.flush     = ($urandom_range(0, 9) == 0);
            check_cycle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
